ram_bank_be: RTL and testbench

RAM_BANK_BE -- requirements
Module: ram_bank_be

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_rd_pipe.sv | 61 ++++++
 rtl/ram_bank_be.sv | 91 +++++++++
 tb/tb_ram_bank_be.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enabled RAM bank.
package ram_pkg;

  typedef enum logic [0:0] {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_t;

  // Number of 8-bit byte lanes in a word of the given width.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Response delay line: one register stage per cycle of read latency (1 or 2).
module ram_rd_pipe #(
  parameter int RD_LAT = 1,
  parameter int DATA_W = 32
) (
  input  logic              ram_clk,
  input  logic              ram_rst_p,
  input  logic              req_valid,
  input  logic              req_err,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data
);

  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  // req_data is already zero for anything that is not a valid read.
  always_ff @(posedge ram_clk or posedge ram_rst_p) begin
    if (ram_rst_p) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= req_valid;
      s1_err   <= req_err;
      s1_data  <= req_data;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [DATA_W-1:0] s2_data;

      always_ff @(posedge ram_clk or posedge ram_rst_p) begin
        if (ram_rst_p) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          s2_data  <= s1_data;
        end
      end

      assign rsp_valid = s2_valid;
      assign rsp_err   = s2_err;
      assign rsp_data  = s2_data;
    end else begin : g_lat1
      assign rsp_valid = s1_valid;
      assign rsp_err   = s1_err;
      assign rsp_data  = s1_data;
    end
  endgenerate

endmodule

// File: rtl/ram_bank_be.sv
// Single-port RAM bank with byte-lane writes, range checking and an optional
// post-reset clear sequence. Requests are accepted when ram_en && ram_ready.
module ram_bank_be
  import ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 2048,
  parameter int ADDR_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                ram_clk,
  input  logic                ram_rst_p,
  input  logic                ram_en,
  input  logic [DATA_W/8-1:0] ram_we,
  input  logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_wr,
  output logic [DATA_W-1:0]   ram_rd,
  output logic                ram_rvalid,
  output logic                ram_err,
  output logic                ram_ready
);

  localparam int LANES = lane_count(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_state_t        state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              is_write;
  logic              do_write;
  logic              do_read;
  logic              clr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign ram_ready = (state == RAM_RUN);
  assign accept    = ram_en && ram_ready;
  // Full-width compare so high address bits never alias onto valid words.
  assign in_range  = (64'(ram_addr) < 64'(DEPTH));
  assign is_write  = |ram_we;
  assign do_write  = accept && is_write && in_range;
  assign do_read   = accept && !is_write && in_range;
  assign idx       = ram_addr[IDX_W-1:0];
  assign clr_en    = (state == RAM_INIT) && (CLEAR_ON_RST != 0) && !ram_rst_p;
  assign rd_word   = do_read ? mem[idx] : '0;

  always_ff @(posedge ram_clk or posedge ram_rst_p) begin
    if (ram_rst_p) begin
      state   <= RAM_INIT;
      clr_idx <= '0;
    end else if (state == RAM_INIT) begin
      if ((CLEAR_ON_RST == 0) || (clr_idx == IDX_W'(DEPTH - 1))) begin
        state <= RAM_RUN;
      end else begin
        clr_idx <= clr_idx + 1'b1;
      end
    end
  end

  // The array has no reset; contents are only zeroed by the INIT sweep.
  always_ff @(posedge ram_clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (do_write) begin
      for (int b = 0; b < LANES; b++) begin
        if (ram_we[b]) begin
          mem[idx][8*b +: 8] <= ram_wr[8*b +: 8];
        end
      end
    end
  end

  ram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_rd_pipe (
    .ram_clk   (ram_clk),
    .ram_rst_p (ram_rst_p),
    .req_valid (accept && !is_write),
    .req_err   (accept && !in_range),
    .req_data  (rd_word),
    .rsp_valid (ram_rvalid),
    .rsp_err   (ram_err),
    .rsp_data  (ram_rd)
  );

endmodule

// File: tb/tb_ram_bank_be.sv
// Directed bench for ram_bank_be: three instances (latency 1, latency 2, no clear)
// share one request stream.
module tb_ram_bank_be;

  logic        ram_clk   = 1'b0;
  logic        ram_rst_p = 1'b0;
  logic        ram_en    = 1'b0;
  logic [3:0]  ram_we    = '0;
  logic [31:0] ram_addr  = '0;
  logic [31:0] ram_wr    = '0;

  logic [31:0] rd1, rd2, rd3;
  logic        rv1, rv2, rv3, er1, er2, er3, rdy1, rdy2, rdy3;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  rsp_t        nxt, exp1, exp2;
  logic [31:0] model_mem [16];
  logic        model_ready = 1'b0;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 ram_clk = ~ram_clk;

  ram_bank_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RST(1)) dut1 (
    .ram_clk(ram_clk), .ram_rst_p(ram_rst_p), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(rd1), .ram_rvalid(rv1),
    .ram_err(er1), .ram_ready(rdy1));

  ram_bank_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(2), .CLEAR_ON_RST(1)) dut2 (
    .ram_clk(ram_clk), .ram_rst_p(ram_rst_p), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(rd2), .ram_rvalid(rv2),
    .ram_err(er2), .ram_ready(rdy2));

  ram_bank_be #(.DATA_W(32), .DEPTH(16), .ADDR_W(32), .RD_LAT(1), .CLEAR_ON_RST(0)) dut3 (
    .ram_clk(ram_clk), .ram_rst_p(ram_rst_p), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_rd(rd3), .ram_rvalid(rv3),
    .ram_err(er3), .ram_ready(rdy3));

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wr);
    ram_en   = 1'b1;
    ram_we   = we;
    ram_addr = addr;
    ram_wr   = wr;
    nxt      = '0;
    if (model_ready) begin
      if (addr >= 32'd16) begin
        nxt.e = 1'b1;
        nxt.v = (we == 4'h0);
      end else if (we == 4'h0) begin
        nxt.v = 1'b1;
        nxt.d = model_mem[addr[3:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[b]) model_mem[addr[3:0]][8*b +: 8] = wr[8*b +: 8];
      end
    end
  endtask

  task automatic step();
    @(posedge ram_clk);
    #1;
    exp2     = exp1;
    exp1     = nxt;
    nxt      = '0;
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_wr   = '0;
  endtask

  task automatic assert_reset();
    ram_rst_p   = 1'b1;
    model_ready = 1'b0;
    nxt         = '0;
    exp1        = '0;
    exp2        = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    assert_reset();
    #2;
    checks++;
    if ({rdy1, rv1, er1, rd1} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs_dut1 got %b_%b_%b_%h want all zero", rdy1, rv1, er1, rd1);
    end
    checks++;
    if ({rdy2, rv2, er2, rd2, rdy3} !== 36'd0) begin
      errors++; $display("FAIL reset_outputs_dut2_3 got %b_%b_%b_%h_%b want all zero", rdy2, rv2, er2, rd2, rdy3);
    end
    step();
    step();
    ram_rst_p = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      checks++;
      if (rdy1 !== (i == 16) || rdy2 !== (i == 16)) begin
        errors++; $display("FAIL ready_rise cycle %0d got %b/%b want %b", i, rdy1, rdy2, (i == 16));
      end
      if (i == 1) begin
        checks++;
        if (rdy3 !== 1'b1) begin
          errors++; $display("FAIL no_clear_ready got %b want 1", rdy3);
        end
      end
    end
    model_ready = 1'b1;
    for (int k = 0; k < 16; k++) model_mem[k] = '0;
  endtask

  task automatic test_clear_reads();
    for (int i = 0; i < 18; i++) begin
      if (i < 16) issue(4'h0, 32'(i), 32'h0);
      step();
      checks++;
      if ({rv1, er1, rd1} !== {(i < 16), 1'b0, 32'h0}) begin
        errors++; $display("FAIL clear_read_dut1 step %0d got v=%b e=%b d=%h want v=%b e=0 d=0", i, rv1, er1, rd1, (i < 16));
      end
      checks++;
      if ({rv2, er2, rd2} !== {(i >= 1 && i <= 16), 1'b0, 32'h0}) begin
        errors++; $display("FAIL clear_read_dut2 step %0d got v=%b e=%b d=%h want v=%b e=0 d=0", i, rv2, er2, rd2, (i >= 1 && i <= 16));
      end
    end
  endtask

  task automatic test_byte_lanes();
    issue(4'hF, 32'd5, 32'hDEAD_BEEF);
    step();
    checks++;
    if ({rv1, er1} !== 2'b00) begin
      errors++; $display("FAIL write_no_rvalid got v=%b e=%b want 0 0", rv1, er1);
    end
    issue(4'h1, 32'd5, 32'h0000_00AA);
    step();
    issue(4'h0, 32'd5, 32'h0);
    step();
    checks++;
    if ({rv1, rd1} !== {1'b1, 32'hDEAD_BEAA}) begin
      errors++; $display("FAIL lane0_merge_dut1 got v=%b d=%h want v=1 d=deadbeaa", rv1, rd1);
    end
    issue(4'b0110, 32'd5, 32'h1122_3344);
    step();
    checks++;
    if ({rv2, rd2} !== {1'b1, 32'hDEAD_BEAA}) begin
      errors++; $display("FAIL lane0_merge_dut2 got v=%b d=%h want v=1 d=deadbeaa", rv2, rd2);
    end
    issue(4'h0, 32'd5, 32'h0);
    step();
    checks++;
    if ({rv1, rd1} !== {1'b1, 32'hDE22_33AA}) begin
      errors++; $display("FAIL mid_lanes_dut1 got v=%b d=%h want v=1 d=de2233aa", rv1, rd1);
    end
    step();
    checks++;
    if ({rv2, rd2} !== {1'b1, 32'hDE22_33AA}) begin
      errors++; $display("FAIL mid_lanes_dut2 got v=%b d=%h want v=1 d=de2233aa", rv2, rd2);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  we_t   [8] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [31:0] addr_t [8] = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0};
    logic [31:0] wr_t   [8] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 0, 0, 0, 0, 0};
    logic [31:0] got;
    int          first = -1;
    int          last  = -1;
    int          pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 6) issue(we_t[i], addr_t[i], wr_t[i]);
      if (i >= 3 && i < 6) exp_q.push_back(wr_t[i - 3]);
      step();
      checks++;
      if ({rv1, er1, rd1} !== exp1) begin
        errors++; $display("FAIL b2b_dut1 step %0d got v=%b e=%b d=%h want v=%b e=%b d=%h", i, rv1, er1, rd1, exp1.v, exp1.e, exp1.d);
      end
      if (rv2 === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
        got = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (rd2 !== got) begin
          errors++; $display("FAIL b2b_order_dut2 step %0d got %h want %h", i, rd2, got);
        end
      end
    end
    checks++;
    if (pulses != 3 || first != 4 || last != 6) begin
      errors++; $display("FAIL b2b_pulses_dut2 got n=%0d first=%0d last=%0d want n=3 first=4 last=6", pulses, first, last);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0]  we_t   [8] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [31:0] addr_t [8] = '{32'd16, 32'd16, 32'h8000_0005, 32'hFFFF_FFF0, 32'd15, 32'd0, 32'd15, 32'd0};
    logic [31:0] wr_t   [8] = '{0, 32'hFFFF_FFFF, 0, 0, 32'h0F0F_0F0F, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      if (i < 7) issue(we_t[i], addr_t[i], wr_t[i]);
      step();
      if (i == 0) begin
        checks++;
        if ({rv1, er1, rd1} !== {1'b1, 1'b1, 32'h0}) begin
          errors++; $display("FAIL oor_read_dut1 got v=%b e=%b d=%h want 1 1 0", rv1, er1, rd1);
        end
      end
      if (i == 1) begin
        checks++;
        if ({rv1, er1} !== 2'b01) begin
          errors++; $display("FAIL oor_write_dut1 got v=%b e=%b want 0 1", rv1, er1);
        end
      end
      checks++;
      if ({rv1, er1, rd1} !== exp1) begin
        errors++; $display("FAIL oor_dut1 step %0d got v=%b e=%b d=%h want v=%b e=%b d=%h", i, rv1, er1, rd1, exp1.v, exp1.e, exp1.d);
      end
      checks++;
      if ({rv2, er2, rd2} !== exp2) begin
        errors++; $display("FAIL oor_dut2 step %0d got v=%b e=%b d=%h want v=%b e=%b d=%h", i, rv2, er2, rd2, exp2.v, exp2.e, exp2.d);
      end
    end
  endtask

  task automatic test_reset_inflight();
    issue(4'h0, 32'd5, 32'h0);
    step();
    assert_reset();
    #1;
    checks++;
    if ({rdy1, rv1, er1, rd1, rdy2, rv2, er2, rd2} !== 70'd0) begin
      errors++; $display("FAIL async_reset got %b_%b_%b_%h %b_%b_%b_%h want all zero", rdy1, rv1, er1, rd1, rdy2, rv2, er2, rd2);
    end
    step();
    ram_rst_p = 1'b0;
    // Seven clear cycles, with requests that must be dropped while not ready.
    for (int i = 0; i < 7; i++) begin
      issue((i % 2 == 0) ? 4'hF : 4'h0, 32'd9, 32'hCAFE_0009);
      step();
      checks++;
      if ({rdy1, rv1, er1, rdy2, rv2, er2} !== 6'b0) begin
        errors++; $display("FAIL init_drop step %0d got %b%b%b %b%b%b want 000 000", i, rdy1, rv1, er1, rdy2, rv2, er2);
      end
    end
    assert_reset();
    step();
    ram_rst_p = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i < 16) issue(4'hF, 32'd9, 32'hCAFE_0009);
      step();
      checks++;
      if ({rdy1, rdy2} !== {2{(i == 16)}} || {rv1, er1, rv2, er2} !== 4'b0) begin
        errors++; $display("FAIL restart_ready cycle %0d got rdy=%b%b v/e=%b%b%b%b want rdy=%b no response", i, rdy1, rdy2, rv1, er1, rv2, er2, (i == 16));
      end
    end
    model_ready = 1'b1;
    for (int k = 0; k < 16; k++) model_mem[k] = '0;
    issue(4'h0, 32'd9, 32'h0);
    step();
    checks++;
    if ({rv1, rd1} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL dropped_write_dut1 got v=%b d=%h want v=1 d=0", rv1, rd1);
    end
    issue(4'h0, 32'd1, 32'h0);
    step();
    checks++;
    if ({rv1, er1, rd1} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL recleared_dut1 got v=%b e=%b d=%h want 1 0 0", rv1, er1, rd1);
    end
    checks++;
    if ({rv3, er3, rd3} !== {1'b1, 1'b0, 32'h1111_0001}) begin
      errors++; $display("FAIL no_clear_keep_dut3 got v=%b e=%b d=%h want 1 0 11110001", rv3, er3, rd3);
    end
    checks++;
    if ({rv2, rd2} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL dropped_write_dut2 got v=%b d=%h want v=1 d=0", rv2, rd2);
    end
    step();
    checks++;
    if ({rv1, rv2, rd2} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL tail_dut2 got v1=%b v2=%b d=%h want 0 1 0", rv1, rv2, rd2);
    end
  endtask

  initial begin
    nxt  = '0;
    exp1 = '0;
    exp2 = '0;
    test_reset();
    test_clear_reads();
    test_byte_lanes();
    test_back_to_back();
    test_out_of_range();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
